// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the multi-channel PWM capture block.
// Build with PWM_CAPTURE_TIMEOUT_EN defined to enable per-channel loss-of-signal detection.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ch_state_e;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_TIMEOUT = 32'd50_000_000;

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchroniser, edge detect, period/high-time FSM and result registers.
// PWM_CAPTURE_TIMEOUT_EN adds the loss-of-signal comparator; otherwise timeout_o stays 0.
module pwm_capture_ch
    import pwm_capture_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    input  logic             en,
    output logic [WIDTH-1:0] period_o,
    output logic [WIDTH-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o
);

    // [0],[1] form the synchroniser, [2] is the edge-detect history
    logic [2:0]       shift_q, shift_d;
    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_latch_q, hi_latch_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic rise;
    logic fall;
    logic timeout_hit;

    assign rise = shift_q[1] & ~shift_q[2];
    assign fall = ~shift_q[1] & shift_q[2];

`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    assign timeout_hit = (cnt_q >= TIMEOUT_W);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        shift_d    = {shift_q[1:0], pwm_in};
        state_d    = state_q;
        cnt_d      = (state_q != IDLE && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        hi_latch_d = hi_latch_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;

        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            hi_latch_d = '0;
            period_d   = '0;
            high_d     = '0;
            timeout_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = WIDTH'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d    = LOW;
                        hi_latch_d = cnt_q;
                    end else if (timeout_hit) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end
                end
                LOW: begin
                    // A real edge wins over a timeout landing in the same cycle
                    if (rise) begin
                        state_d   = HIGH;
                        period_d  = cnt_q;
                        high_d    = hi_latch_q;
                        valid_d   = 1'b1;
                        cnt_d     = WIDTH'(1);
                        timeout_d = 1'b0;
                    end else if (timeout_hit) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_latch_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_latch_q <= hi_latch_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM capture top: CHANNELS independent pwm_capture_ch instances on packed buses.
// Loss-of-signal detection is compiled in only when PWM_CAPTURE_TIMEOUT_EN is defined.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       pwm_in,
    input  logic [CHANNELS-1:0]       en,
    output logic [CHANNELS*WIDTH-1:0] period_o,
    output logic [CHANNELS*WIDTH-1:0] high_o,
    output logic [CHANNELS-1:0]       valid_o,
    output logic [CHANNELS-1:0]       timeout_o
);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        pwm_capture_ch #(
            .WIDTH   (WIDTH),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pwm_in    (pwm_in[gi]),
            .en        (en[gi]),
            .period_o  (period_o[gi*WIDTH +: WIDTH]),
            .high_o    (high_o[gi*WIDTH +: WIDTH]),
            .valid_o   (valid_o[gi]),
            .timeout_o (timeout_o[gi])
        );
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: 4 channels, 16-bit counters, TIMEOUT=100.
// Works with or without PWM_CAPTURE_TIMEOUT_EN; expectations adapt to the build.
module tb_pwm_capture;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int TO = 100;
`ifdef PWM_CAPTURE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   pwm_in;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] period_o;
    logic [CH*W-1:0] high_o;
    logic [CH-1:0]   valid_o;
    logic [CH-1:0]   timeout_o;

    pwm_capture #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .en        (en),
        .period_o  (period_o),
        .high_o    (high_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vcount [CH];
    int last_v [CH];
    int prev_v [CH];
    int gen_hi [CH];
    int gen_lo [CH];
    int gen_ph [CH];
    bit gen_on [CH];
    logic gen_force [CH];
    logic [CH-1:0] en_v;
    int s, s2, s3, s4, v0;

    function automatic int per_of(input int ch);
        return int'(period_o[ch*W +: W]);
    endfunction

    function automatic int hi_of(input int ch);
        return int'(high_o[ch*W +: W]);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive the next inputs
    task automatic cycle();
        @(negedge clk);
        cyc++;
        for (int c = 0; c < CH; c++) begin
            if (valid_o[c]) begin
                vcount[c]++;
                prev_v[c] = last_v[c];
                last_v[c] = cyc;
                $display("cyc %0d ch%0d valid period=%0d high=%0d", cyc, c, per_of(c), hi_of(c));
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (gen_on[c]) begin
                pwm_in[c] = (gen_ph[c] < gen_hi[c]);
                gen_ph[c] = (gen_ph[c] + 1) % (gen_hi[c] + gen_lo[c]);
            end else begin
                pwm_in[c] = gen_force[c];
            end
        end
        en = en_v;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle();
    endtask

    task automatic start_gen(input int c, input int hi, input int lo, input int ph);
        gen_on[c] = 1'b1;
        gen_hi[c] = hi;
        gen_lo[c] = lo;
        gen_ph[c] = ph;
    endtask

    task automatic hold(input int c, input logic v);
        gen_on[c]    = 1'b0;
        gen_force[c] = v;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            vcount[c] = 0;
            last_v[c] = 0;
            prev_v[c] = 0;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pwm_in = '0;
        en_v   = '1;
        en     = '1;
        for (int c = 0; c < CH; c++) hold(c, 1'b0);
        clear_counts();

        // Reset state
        repeat (3) cycle();
        check("rst_period0", per_of(0), 0);
        check("rst_high0", hi_of(0), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_timeout", int'(timeout_o), 0);
        rst_n = 1'b1;

        // Channel 0, 10 high / 10 low
        start_gen(0, 10, 10, 0);
        s = cyc + 1;
        run_to(s + 22);
        check("sq_no_early_valid", vcount[0], 0);
        run_to(s + 23);
        check("sq_first_valid", int'(valid_o[0]), 1);
        check("sq_period", per_of(0), 20);
        check("sq_high", hi_of(0), 10);
        run_to(s + 24);
        check("sq_valid_one_cycle", int'(valid_o[0]), 0);
        run_to(s + 99);
        check("sq_valid_count", vcount[0], 4);
        check("sq_valid_spacing", last_v[0] - prev_v[0], 20);
        check("sq_other_quiet", vcount[1] + vcount[2] + vcount[3], 0);

        // en low clears results
        hold(0, 1'b0);
        en_v[0] = 1'b0;
        repeat (5) cycle();
        check("en_low_period", per_of(0), 0);
        check("en_low_high", hi_of(0), 0);

        // Channel 3 at 1/1 alongside channel 0 at 7/13
        clear_counts();
        en_v[0] = 1'b1;
        start_gen(0, 7, 13, 0);
        start_gen(3, 1, 1, 0);
        s = cyc + 1;
        run_to(s + 99);
        check("fast_period3", per_of(3), 2);
        check("fast_high3", hi_of(3), 1);
        check("fast_count3", vcount[3], 48);
        check("fast_spacing3", last_v[3] - prev_v[3], 2);
        check("mix_period0", per_of(0), 20);
        check("mix_high0", hi_of(0), 7);
        check("mix_count0", vcount[0], 4);
        check("mix_quiet12", vcount[1] + vcount[2], 0);

        // Two good periods, then stuck high
        hold(3, 1'b0);
        hold(0, 1'b0);
        en_v[0] = 1'b0;
        repeat (5) cycle();
        clear_counts();
        en_v[0] = 1'b1;
        start_gen(0, 10, 10, 0);
        s = cyc + 1;
        run_to(s + 40);
        hold(0, 1'b1);
        run_to(s + 142);
        check("stuck_valids", vcount[0], 2);
        check("stuck_to_before", int'(timeout_o[0]), 0);
        run_to(s + 143);
        check("stuck_to_after", int'(timeout_o[0]), int'(TO_EN));
        check("stuck_hold_period", per_of(0), 20);
        check("stuck_hold_high", hi_of(0), 10);

        // Signal returns: low 10, high 10, low 10, high
        clear_counts();
        start_gen(0, 10, 10, 10);
        s2 = cyc + 1;
        run_to(s2 + 32);
        check("recover_to_sticky", int'(timeout_o[0]), int'(TO_EN));
        run_to(s2 + 33);
        check("recover_valid", int'(valid_o[0]), 1);
        check("recover_count", vcount[0], TO_EN ? 1 : 2);
        check("recover_period", per_of(0), 20);
        check("recover_high", hi_of(0), 10);
        check("recover_to_clear", int'(timeout_o[0]), 0);

        // en drop in the same cycle the fall is detected
        hold(0, 1'b0);
        repeat (5) cycle();
        start_gen(0, 10, 10, 0);
        s3 = cyc + 1;
        run_to(s3 + 31);
        check("pre_drop_period", per_of(0), 20);
        v0 = vcount[0];
        en_v[0] = 1'b0;
        run_to(s3 + 33);
        check("drop_period", per_of(0), 0);
        check("drop_high", hi_of(0), 0);
        check("drop_valid", int'(valid_o[0]), 0);
        run_to(s3 + 42);
        en_v[0] = 1'b1;
        run_to(s3 + 82);
        check("reen_no_valid", vcount[0] - v0, 0);
        check("reen_period_zero", per_of(0), 0);
        run_to(s3 + 83);
        check("reen_valid", vcount[0] - v0, 1);
        check("reen_period", per_of(0), 20);
        check("reen_high", hi_of(0), 10);

        // Asynchronous reset while channel 0 is in LOW
        run_to(s3 + 95);
        #2 rst_n = 1'b0;
        #1;
        check("arst_period0", per_of(0), 0);
        check("arst_high0", hi_of(0), 0);
        check("arst_period3", per_of(3), 0);
        check("arst_valid", int'(valid_o), 0);
        check("arst_timeout", int'(timeout_o), 0);
        hold(0, 1'b1);
        en_v[0] = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;

        // Input already high when enabled; first edge seen is a fall
        repeat (5) cycle();
        en_v[0] = 1'b1;
        repeat (3) cycle();
        clear_counts();
        start_gen(0, 10, 10, 10);
        s4 = cyc + 1;
        run_to(s4 + 32);
        check("fallfirst_no_valid", vcount[0], 0);
        check("fallfirst_period0", per_of(0), 0);
        run_to(s4 + 33);
        check("fallfirst_valid", vcount[0], 1);
        check("fallfirst_period", per_of(0), 20);
        check("fallfirst_high", hi_of(0), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
